// File: rtl/pipeline_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit_pkg
// Shared definitions for the pipeline hazard unit:
//   hz_state_e  - control FSM states (RUN / STALL / FLUSH / HALTED)
//   FWD_*       - forwarding-select encodings for one source operand
//   cnt_init()  - down-counter preload for a multi-cycle stall or flush
// -----------------------------------------------------------------------------
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } hz_state_e;

    localparam logic [1:0] FWD_NONE = 2'd0;  // register file
    localparam logic [1:0] FWD_WB   = 2'd1;  // MEM/WB result
    localparam logic [1:0] FWD_MEM  = 2'd2;  // EX/MEM result

    localparam int CNT_W = 3;

    // The first cycle of a stall/flush is spent in RUN (the detecting cycle)
    // and the last one is the counter==0 cycle, so preload with cycles-2.
    function automatic logic [CNT_W-1:0] cnt_init(input int cycles);
        return (cycles > 1) ? CNT_W'(cycles - 2) : '0;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Address comparison for one decode-stage source operand.
// Ports:
//   rs, rs_used                 - operand address and read enable
//   ex_rd                       - destination in EX (load-use candidate)
//   mem_rd, mem_reg_write       - EX/MEM destination and write enable
//   wb_rd, wb_reg_write         - MEM/WB destination and write enable
//   fwd_sel                     - FWD_MEM / FWD_WB / FWD_NONE
//   ex_match                    - operand reads the EX destination
// -----------------------------------------------------------------------------
module hazard_src_match
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int RA_W               = 2,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic [RA_W-1:0] rs,
    input  logic            rs_used,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    output logic [1:0]      fwd_sel,
    output logic            ex_match
);

    logic live;

    // A hardwired r0 can never carry a dependency, so it is treated as unused.
    assign live = rs_used && !((ZERO_REG_HARDWIRED != 0) && (rs == '0));

    always_comb begin
        fwd_sel = FWD_NONE;
        if (live && mem_reg_write && (mem_rd == rs)) begin
            fwd_sel = FWD_MEM;          // youngest producer wins
        end else if (live && wb_reg_write && (wb_rd == rs)) begin
            fwd_sel = FWD_WB;
        end
    end

    assign ex_match = live && (ex_rd == rs);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
// Forwarding selection, load-use stalls, redirect flushes and halt for a
// classic 5-stage pipeline.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   id_valid, id_rs, id_rs_used  - decode instruction and its source operands
//   ex_/mem_/wb_rd, *_reg_write  - destination of the instructions ahead
//   ex_mem_read                  - EX instruction is a load
//   redirect, halt               - taken branch/jump; HLT reached writeback
//   fwd_sel                      - 2-bit select per operand
//   pc_write, ifid_write         - front-end enables
//   idex_bubble, ifid_flush      - NOP into ID/EX; invalidate IF/ID
//   halted, stall_cnt            - core stopped; saturating bubble count
//   dbg_state                    - current FSM state (hz_state_e encoding)
// Handshake note: no valid/ready pairs here; every output is a level that
// applies to the current cycle, and the FSM changes only on clk rising edges.
// -----------------------------------------------------------------------------
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int NUM_REGS           = 4,
    parameter int RA_W               = $clog2(NUM_REGS),
    parameter int NUM_SRC            = 2,
    parameter int LOAD_LAT           = 1,
    parameter int FLUSH_CYCLES       = 1,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    id_valid,
    input  logic [NUM_SRC*RA_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [RA_W-1:0]         ex_rd,
    input  logic [RA_W-1:0]         mem_rd,
    input  logic [RA_W-1:0]         wb_rd,
    input  logic                    ex_reg_write,
    input  logic                    mem_reg_write,
    input  logic                    wb_reg_write,
    input  logic                    ex_mem_read,
    input  logic                    redirect,
    input  logic                    halt,
    output logic [2*NUM_SRC-1:0]    fwd_sel,
    output logic                    pc_write,
    output logic                    ifid_write,
    output logic                    idex_bubble,
    output logic                    ifid_flush,
    output logic                    halted,
    output logic [15:0]             stall_cnt,
    output logic [1:0]              dbg_state
);

    localparam logic [CNT_W-1:0] LOAD_INIT  = cnt_init(LOAD_LAT);
    localparam logic [CNT_W-1:0] FLUSH_INIT = cnt_init(FLUSH_CYCLES);
    localparam bit               LOAD_MULTI  = (LOAD_LAT > 1);
    localparam bit               FLUSH_MULTI = (FLUSH_CYCLES > 1);

    hz_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_cnt_q;
    logic [NUM_SRC-1:0] ex_match;
    logic               load_use_hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_match #(
            .RA_W               (RA_W),
            .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
        ) u_match (
            .rs            (id_rs[g*RA_W +: RA_W]),
            .rs_used       (id_rs_used[g]),
            .ex_rd         (ex_rd),
            .mem_rd        (mem_rd),
            .mem_reg_write (mem_reg_write),
            .wb_rd         (wb_rd),
            .wb_reg_write  (wb_reg_write),
            .fwd_sel       (fwd_sel[2*g +: 2]),
            .ex_match      (ex_match[g])
        );
    end

    assign load_use_hit = (state_q == ST_RUN) && id_valid && ex_mem_read &&
                          ex_reg_write && (|ex_match);

    // Priority: halt > redirect > ongoing stall/flush > new load-use hit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        halted      = 1'b0;

        if (state_q == ST_HALTED) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else if (halt) begin
            // Freeze the front end already in the halt cycle.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_HALTED;
            cnt_d       = '0;
        end else if (redirect) begin
            // Aborts any stall; a redirect during FLUSH restarts the count.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d       = FLUSH_INIT;
        end else if (state_q == ST_STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (state_q == ST_FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (load_use_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LOAD_MULTI ? ST_STALL : ST_RUN;
            cnt_d       = LOAD_INIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (idex_bubble && (state_q != ST_HALTED) &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: dut_a uses LOAD_LAT=3, FLUSH_CYCLES=2, hardwired r0;
// dut_b uses the defaults. Both see the same stimulus.
module tb_pipeline_hazard_unit;
  import pipeline_hazard_unit_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [3:0] id_rs;
  logic [1:0] id_rs_used;
  logic [1:0] ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
  logic       redirect, halt;

  logic [3:0]  fwd_a, fwd_b;
  logic        pc_a, pc_b, ifw_a, ifw_b, bub_a, bub_b, fl_a, fl_b, hlt_a, hlt_b;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  st_a, st_b;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_hazard_unit #(.NUM_REGS(4), .NUM_SRC(2), .LOAD_LAT(3),
                         .FLUSH_CYCLES(2), .ZERO_REG_HARDWIRED(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
    .redirect(redirect), .halt(halt), .fwd_sel(fwd_a), .pc_write(pc_a),
    .ifid_write(ifw_a), .idex_bubble(bub_a), .ifid_flush(fl_a),
    .halted(hlt_a), .stall_cnt(cnt_a), .dbg_state(st_a));

  pipeline_hazard_unit dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
    .redirect(redirect), .halt(halt), .fwd_sel(fwd_b), .pc_write(pc_b),
    .ifid_write(ifw_b), .idex_bubble(bub_b), .ifid_flush(fl_b),
    .halted(hlt_b), .stall_cnt(cnt_b), .dbg_state(st_b));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_valid = 0; id_rs = '0; id_rs_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_mem_read = 0;
    redirect = 0; halt = 0;
  endtask

  // load in EX writing r1; decode reads r1 (operand 1) and r3 (operand 0)
  task automatic drive_load_hit();
    id_valid = 1; id_rs = {2'd1, 2'd3}; id_rs_used = 2'b11;
    ex_rd = 2'd1; ex_reg_write = 1; ex_mem_read = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0;
    drive_idle();
    repeat (3) @(negedge clk);
    id_rs = {2'd1, 2'd2}; id_rs_used = 2'b11; mem_rd = 2'd2; mem_reg_write = 1;
    #1;
    n_cmp++; if (pc_a !== 1'b1 || ifw_a !== 1'b1) begin n_bad++; $display("FAIL reset_enables got pc=%b ifid=%b want 1 1", pc_a, ifw_a); end
    n_cmp++; if (bub_a !== 1'b0 || fl_a !== 1'b0 || hlt_a !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got bub=%b fl=%b hlt=%b want 0 0 0", bub_a, fl_a, hlt_a); end
    n_cmp++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt_a, cnt_b); end
    n_cmp++; if (st_a !== ST_RUN) begin n_bad++; $display("FAIL reset_state got %0d want 0", st_a); end
    n_cmp++; if (fwd_a !== 4'b0010) begin n_bad++; $display("FAIL reset_fwd got %b want 0010", fwd_a); end
    @(negedge clk);
    drive_idle();
    reset_n = 1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive_idle();
    id_rs = {2'd1, 2'd2}; id_rs_used = 2'b11;
    mem_rd = 2'd2; mem_reg_write = 1; wb_rd = 2'd2; wb_reg_write = 1;
    #1;
    n_cmp++; if (fwd_a !== 4'b0010) begin n_bad++; $display("FAIL fwd_mem got %b want 0010", fwd_a); end
    mem_reg_write = 0; #1;
    n_cmp++; if (fwd_a !== 4'b0001) begin n_bad++; $display("FAIL fwd_wb got %b want 0001", fwd_a); end
    wb_rd = 2'd1; #1;
    n_cmp++; if (fwd_a !== 4'b0100) begin n_bad++; $display("FAIL fwd_wb_op1 got %b want 0100", fwd_a); end
    mem_rd = 2'd1; mem_reg_write = 1; #1;
    n_cmp++; if (fwd_b !== 4'b1000) begin n_bad++; $display("FAIL fwd_mem_over_wb got %b want 1000", fwd_b); end
    id_rs_used = 2'b01; #1;
    n_cmp++; if (fwd_a !== 4'b0000) begin n_bad++; $display("FAIL fwd_unused got %b want 0000", fwd_a); end
    n_cmp++; if (pc_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL fwd_no_stall got pc=%b bub=%b want 1 0", pc_a, bub_a); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive_idle();
    id_rs = 4'b0000; id_rs_used = 2'b11; mem_rd = 2'd0; mem_reg_write = 1;
    #1;
    n_cmp++; if (fwd_a !== 4'b0000) begin n_bad++; $display("FAIL zero_fwd_hw got %b want 0000", fwd_a); end
    n_cmp++; if (fwd_b !== 4'b1010) begin n_bad++; $display("FAIL zero_fwd_soft got %b want 1010", fwd_b); end
    mem_reg_write = 0; id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2'd0;
    #1;
    n_cmp++; if (pc_a !== 1'b1 || bub_a !== 1'b0) begin n_bad++; $display("FAIL zero_load_hw got pc=%b bub=%b want 1 0", pc_a, bub_a); end
    n_cmp++; if (pc_b !== 1'b0 || bub_b !== 1'b1) begin n_bad++; $display("FAIL zero_load_soft got pc=%b bub=%b want 0 1", pc_b, bub_b); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (cnt_a !== 16'd0 || cnt_b !== 16'd1) begin n_bad++; $display("FAIL zero_cnt got %0d/%0d want 0/1", cnt_a, cnt_b); end
    n_cmp++; if (pc_b !== 1'b1 || st_b !== ST_RUN) begin n_bad++; $display("FAIL lat1_resume got pc=%b st=%0d want 1 0", pc_b, st_b); end
  endtask

  task automatic test_load_use();
    int low_a = 0;
    int low_b = 0;
    @(negedge clk);
    drive_idle();
    drive_load_hit();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin ex_mem_read = 0; ex_reg_write = 0; end
      #1;
      if (pc_a === 1'b0) low_a++;
      if (pc_b === 1'b0) low_b++;
      if (i == 0) begin
        n_cmp++; if (ifw_a !== 1'b0 || bub_a !== 1'b1) begin n_bad++; $display("FAIL lu_hit_cycle got ifid=%b bub=%b want 0 1", ifw_a, bub_a); end
      end
      if (i == 1) begin
        n_cmp++; if (st_a !== ST_STALL) begin n_bad++; $display("FAIL lu_state got %0d want 1", st_a); end
      end
    end
    n_cmp++; if (low_a != 3) begin n_bad++; $display("FAIL lu_len_lat3 got %0d want 3", low_a); end
    n_cmp++; if (low_b != 1) begin n_bad++; $display("FAIL lu_len_lat1 got %0d want 1", low_b); end
    n_cmp++; if (cnt_a !== 16'd3 || cnt_b !== 16'd2) begin n_bad++; $display("FAIL lu_cnt got %0d/%0d want 3/2", cnt_a, cnt_b); end
  endtask

  task automatic test_redirect_priority();
    int bubs = 0;
    int pc_low = 0;
    @(negedge clk);
    drive_idle();
    drive_load_hit();
    redirect = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) drive_idle();
      #1;
      if (bub_a === 1'b1) bubs++;
      if (pc_a === 1'b0) pc_low++;
      if (i == 0) begin
        n_cmp++; if (fl_a !== 1'b1 || pc_a !== 1'b1) begin n_bad++; $display("FAIL rd_over_lu got fl=%b pc=%b want 1 1", fl_a, pc_a); end
      end
      if (i == 1) begin
        n_cmp++; if (st_a !== ST_FLUSH) begin n_bad++; $display("FAIL rd_state got %0d want 2", st_a); end
      end
    end
    n_cmp++; if (bubs != 2) begin n_bad++; $display("FAIL rd_bubbles got %0d want 2", bubs); end
    n_cmp++; if (pc_low != 0) begin n_bad++; $display("FAIL rd_no_stall got %0d want 0", pc_low); end
    n_cmp++; if (cnt_a !== 16'd5 || cnt_b !== 16'd3) begin n_bad++; $display("FAIL rd_cnt got %0d/%0d want 5/3", cnt_a, cnt_b); end
  endtask

  task automatic test_back_to_back_redirect();
    int bubs = 0;
    @(negedge clk);
    drive_idle();
    redirect = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) redirect = 0;
      #1;
      if (bub_a === 1'b1) bubs++;
      if (i == 1) begin
        n_cmp++; if (fl_a !== 1'b1 || st_a !== ST_FLUSH) begin n_bad++; $display("FAIL b2b_in_flush got fl=%b st=%0d want 1 2", fl_a, st_a); end
      end
    end
    n_cmp++; if (bubs != 3) begin n_bad++; $display("FAIL b2b_bubbles got %0d want 3", bubs); end
    n_cmp++; if (cnt_a !== 16'd8 || cnt_b !== 16'd5) begin n_bad++; $display("FAIL b2b_cnt got %0d/%0d want 8/5", cnt_a, cnt_b); end
  endtask

  task automatic test_redirect_aborts_stall();
    @(negedge clk);
    drive_idle();
    drive_load_hit();
    @(negedge clk);
    drive_idle();
    redirect = 1;
    #1;
    n_cmp++; if (pc_a !== 1'b1 || fl_a !== 1'b1 || bub_a !== 1'b1) begin n_bad++; $display("FAIL abort_stall got pc=%b fl=%b bub=%b want 1 1 1", pc_a, fl_a, bub_a); end
    @(negedge clk);
    redirect = 0;
    #1;
    n_cmp++; if (st_a !== ST_FLUSH || pc_a !== 1'b1) begin n_bad++; $display("FAIL abort_flush got st=%0d pc=%b want 2 1", st_a, pc_a); end
    @(negedge clk);
    #1;
    n_cmp++; if (st_a !== ST_RUN || bub_a !== 1'b0) begin n_bad++; $display("FAIL abort_done got st=%0d bub=%b want 0 0", st_a, bub_a); end
    n_cmp++; if (cnt_a !== 16'd11 || cnt_b !== 16'd7) begin n_bad++; $display("FAIL abort_cnt got %0d/%0d want 11/7", cnt_a, cnt_b); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive_idle();
    drive_load_hit();
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (pc_a !== 1'b0 || st_a !== ST_STALL) begin n_bad++; $display("FAIL mid_stall_pre got pc=%b st=%0d want 0 1", pc_a, st_a); end
    #2 reset_n = 0;
    #1;
    n_cmp++; if (pc_a !== 1'b1 || bub_a !== 1'b0 || st_a !== ST_RUN) begin n_bad++; $display("FAIL async_rst got pc=%b bub=%b st=%0d want 1 0 0", pc_a, bub_a, st_a); end
    n_cmp++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin n_bad++; $display("FAIL async_rst_cnt got %0d/%0d want 0/0", cnt_a, cnt_b); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    #1;
    n_cmp++; if (bub_a !== 1'b0 || pc_a !== 1'b1) begin n_bad++; $display("FAIL no_residual got bub=%b pc=%b want 0 1", bub_a, pc_a); end
  endtask

  task automatic test_halt();
    int lost = 0;
    @(negedge clk);
    drive_idle();
    halt = 1; redirect = 1;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (hlt_a !== 1'b1 || hlt_b !== 1'b1 || st_a !== ST_HALTED) begin n_bad++; $display("FAIL halt_enter got %b/%b st=%0d want 1/1 3", hlt_a, hlt_b, st_a); end
    n_cmp++; if (pc_a !== 1'b0 || ifw_a !== 1'b0 || bub_a !== 1'b1) begin n_bad++; $display("FAIL halt_outs got pc=%b ifid=%b bub=%b want 0 0 1", pc_a, ifw_a, bub_a); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 50) redirect = 1;
      if (i == 51) redirect = 0;
      #1;
      if (hlt_a !== 1'b1 || hlt_b !== 1'b1) lost++;
    end
    n_cmp++; if (lost != 0) begin n_bad++; $display("FAIL halt_sticky got %0d lost cycles want 0", lost); end
    n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL halt_cnt_frozen got %0d want 1", cnt_a); end
    @(negedge clk);
    reset_n = 0;
    #1;
    n_cmp++; if (hlt_a !== 1'b0 || pc_a !== 1'b1) begin n_bad++; $display("FAIL halt_reset got hlt=%b pc=%b want 0 1", hlt_a, pc_a); end
    @(negedge clk);
    reset_n = 1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_redirect_priority();
    test_back_to_back_redirect();
    test_redirect_aborts_stall();
    test_reset_mid_stall();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
